// File: rtl/ps2_keymap.sv
// PS/2 set-2 scan-code to ASCII translator: prefix FSM, shift/caps tracking,
// and a small output character FIFO with a sticky overflow flag.
module ps2_keymap #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       rx_error,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       shift_o,
    output logic       caps_o,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BREAK,
        S_EXT_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_lshift;
    logic               r_rshift;
    logic               r_caps;
    logic               r_overflow;
    logic               w_lshift_next;
    logic               w_rshift_next;
    logic               w_caps_next;

    logic [7:0]         w_map_char;
    logic               w_map_hit;
    logic               w_map_letter;
    logic               w_wr_req;
    logic [7:0]         w_wr_data;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   w_rd_ptr_inc;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_out_char;
    logic [7:0]         w_out_char_next;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Unextended make-code table; 0x00 marks an unmapped code.
    always_comb begin
        w_map_char = 8'h00;
        case (code)
            8'h1C: w_map_char = 8'h61;
            8'h32: w_map_char = 8'h62;
            8'h21: w_map_char = 8'h63;
            8'h23: w_map_char = 8'h64;
            8'h24: w_map_char = 8'h65;
            8'h2B: w_map_char = 8'h66;
            8'h34: w_map_char = 8'h67;
            8'h33: w_map_char = 8'h68;
            8'h43: w_map_char = 8'h69;
            8'h3B: w_map_char = 8'h6A;
            8'h42: w_map_char = 8'h6B;
            8'h4B: w_map_char = 8'h6C;
            8'h3A: w_map_char = 8'h6D;
            8'h31: w_map_char = 8'h6E;
            8'h44: w_map_char = 8'h6F;
            8'h4D: w_map_char = 8'h70;
            8'h15: w_map_char = 8'h71;
            8'h2D: w_map_char = 8'h72;
            8'h1B: w_map_char = 8'h73;
            8'h2C: w_map_char = 8'h74;
            8'h3C: w_map_char = 8'h75;
            8'h2A: w_map_char = 8'h76;
            8'h1D: w_map_char = 8'h77;
            8'h22: w_map_char = 8'h78;
            8'h35: w_map_char = 8'h79;
            8'h1A: w_map_char = 8'h7A;
            8'h45: w_map_char = 8'h30;
            8'h16: w_map_char = 8'h31;
            8'h1E: w_map_char = 8'h32;
            8'h26: w_map_char = 8'h33;
            8'h25: w_map_char = 8'h34;
            8'h2E: w_map_char = 8'h35;
            8'h36: w_map_char = 8'h36;
            8'h3D: w_map_char = 8'h37;
            8'h3E: w_map_char = 8'h38;
            8'h46: w_map_char = 8'h39;
            8'h29: w_map_char = 8'h20;
            8'h5A: w_map_char = 8'h0D;
            8'h66: w_map_char = 8'h08;
            default: w_map_char = 8'h00;
        endcase
    end

    assign w_map_hit    = (w_map_char != 8'h00);
    assign w_map_letter = (w_map_char >= 8'h61) && (w_map_char <= 8'h7A);

    // Prefix FSM and modifier tracking; rx_error discards the byte and any prefix.
    always_comb begin
        w_state_next  = r_state;
        w_lshift_next = r_lshift;
        w_rshift_next = r_rshift;
        w_caps_next   = r_caps;
        w_wr_req      = 1'b0;
        w_wr_data     = 8'h00;
        if (rx_error) begin
            w_state_next = S_IDLE;
        end else if (code_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (code == 8'hE0) begin
                        w_state_next = S_EXT;
                    end else if (code == 8'hF0) begin
                        w_state_next = S_BREAK;
                    end else begin
                        w_state_next = S_IDLE;
                        if (code == 8'h12) begin
                            w_lshift_next = 1'b1;
                        end else if (code == 8'h59) begin
                            w_rshift_next = 1'b1;
                        end else if (code == 8'h58) begin
                            w_caps_next = ~r_caps;
                        end else if (w_map_hit) begin
                            w_wr_req  = 1'b1;
                            w_wr_data = (w_map_letter && (shift_o ^ r_caps)) ?
                                        (w_map_char - 8'h20) : w_map_char;
                        end
                    end
                end
                S_EXT: begin
                    if (code == 8'hF0) begin
                        w_state_next = S_EXT_BREAK;
                    end else begin
                        w_state_next = S_IDLE;
                        if (code == 8'h5A) begin
                            w_wr_req  = 1'b1;
                            w_wr_data = 8'h0D;
                        end
                    end
                end
                S_BREAK: begin
                    w_state_next = S_IDLE;
                    if (code == 8'h12) w_lshift_next = 1'b0;
                    if (code == 8'h59) w_rshift_next = 1'b0;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop        = (r_count != '0) && out_ready;
    assign w_push       = w_wr_req && (!w_full || w_pop);
    assign w_drop       = w_wr_req && w_full && !w_pop;
    assign w_rd_ptr_inc = PTR_W'(r_rd_ptr + 1'b1);

    // Registered head: next entry on pop, bypass the incoming byte when the FIFO drains.
    always_comb begin
        w_out_char_next = r_out_char;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_out_char_next = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_out_char_next = w_wr_data;
            end else begin
                w_out_char_next = 8'h00;
            end
        end else if (w_push && (r_count == '0)) begin
            w_out_char_next = w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lshift   <= 1'b0;
            r_rshift   <= 1'b0;
            r_caps     <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_char <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_lshift   <= w_lshift_next;
            r_rshift   <= w_rshift_next;
            r_caps     <= w_caps_next;
            r_overflow <= r_overflow | w_drop;
            r_out_char <= w_out_char_next;
            if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            case ({w_push, w_pop})
                2'b10:   r_count <= CNT_W'(r_count + 1'b1);
                2'b01:   r_count <= CNT_W'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign out_char  = r_out_char;
    assign shift_o   = r_lshift | r_rshift;
    assign caps_o    = r_caps;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_keymap.sv
// Directed bench for ps2_keymap: scan-code sequences with hand-computed ASCII,
// modifier, FIFO-depth and error-recovery expectations.
module tb_ps2_keymap;

    logic       clk;
    logic       reset;
    logic       code_valid;
    logic [7:0] code;
    logic       rx_error;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_char;
    logic       shift_o;
    logic       caps_o;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_keymap #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .rx_error   (rx_error),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .shift_o    (shift_o),
        .caps_o     (caps_o),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, obs, exp);
        end else begin
            $display("ok   %s got=%02h", tag, obs);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, {7'd0, out_valid}, 8'h01);
        check_eq(tag, out_char, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] tbl_code [8] = '{8'h1A, 8'h4D, 8'h45, 8'h46, 8'h29, 8'h66, 8'h5A, 8'h76};
    logic [7:0] tbl_exp  [8] = '{8'h7A, 8'h70, 8'h30, 8'h39, 8'h20, 8'h08, 8'h0D, 8'h00};

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        rx_error   = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        // Reset overrides a coincident code byte.
        code       = 8'h1C;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        reset      = 1'b0;
        check_eq("rst_valid", {7'd0, out_valid}, 8'h00);
        check_eq("rst_char", out_char, 8'h00);
        check_eq("rst_shift", {7'd0, shift_o}, 8'h00);
        check_eq("rst_caps", {7'd0, caps_o}, 8'h00);
        check_eq("rst_ovf", {7'd0, overflow}, 8'h00);

        // Make then break of 'a'.
        send(8'h1C);
        check_eq("a_valid", {7'd0, out_valid}, 8'h01);
        send(8'hF0);
        send(8'h1C);
        pop_chk("a_char", 8'h61);
        check_eq("a_empty", {7'd0, out_valid}, 8'h00);

        // Shift held then released.
        send(8'h12);
        check_eq("shift_on", {7'd0, shift_o}, 8'h01);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check_eq("shift_off", {7'd0, shift_o}, 8'h00);
        send(8'h1C);
        pop_chk("shift_A", 8'h41);
        pop_chk("shift_a", 8'h61);
        check_eq("shift_empty", {7'd0, out_valid}, 8'h00);

        // Caps, caps+shift, digit under shift.
        send(8'h58);
        check_eq("caps_on", {7'd0, caps_o}, 8'h01);
        send(8'h1C);
        send(8'h12);
        send(8'h1C);
        send(8'h16);
        pop_chk("caps_A", 8'h41);
        pop_chk("caps_shift_a", 8'h61);
        pop_chk("caps_digit1", 8'h31);
        send(8'hF0);
        send(8'h12);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check_eq("caps_off", {7'd0, caps_o}, 8'h00);

        // Extended codes.
        send(8'hE0);
        send(8'h5A);
        pop_chk("ext_enter", 8'h0D);
        send(8'hE0);
        send(8'h12);
        check_eq("ext12_empty", {7'd0, out_valid}, 8'h00);
        check_eq("ext12_shift", {7'd0, shift_o}, 8'h00);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        check_eq("extbrk_empty", {7'd0, out_valid}, 8'h00);

        // Map table spot checks, including one unmapped code.
        for (int i = 0; i < 8; i++) begin
            send(tbl_code[i]);
            if (tbl_exp[i] != 8'h00) pop_chk($sformatf("map_%02h", tbl_code[i]), tbl_exp[i]);
            else check_eq($sformatf("map_%02h_none", tbl_code[i]), {7'd0, out_valid}, 8'h00);
        end

        // Overflow: four kept, fifth dropped; then pop+write when full.
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        check_eq("full_no_ovf", {7'd0, overflow}, 8'h00);
        send(8'h24);
        check_eq("ovf_set", {7'd0, overflow}, 8'h01);
        check_eq("ovf_head", out_char, 8'h61);
        code       = 8'h2B;
        code_valid = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        out_ready  = 1'b0;
        pop_chk("full_b", 8'h62);
        pop_chk("full_c", 8'h63);
        pop_chk("full_d", 8'h64);
        pop_chk("full_f", 8'h66);
        check_eq("full_empty", {7'd0, out_valid}, 8'h00);
        check_eq("ovf_sticky", {7'd0, overflow}, 8'h01);
        do_reset();
        check_eq("ovf_cleared", {7'd0, overflow}, 8'h00);

        // rx_error drops a pending break prefix.
        send(8'hF0);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        send(8'h1C);
        pop_chk("rxerr_a", 8'h61);

        // rx_error wins over a coincident byte and leaves shift alone.
        send(8'h12);
        code       = 8'h1C;
        code_valid = 1'b1;
        rx_error   = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        rx_error   = 1'b0;
        check_eq("rxerr_drop", {7'd0, out_valid}, 8'h00);
        check_eq("rxerr_shift", {7'd0, shift_o}, 8'h01);
        send(8'hF0);
        send(8'h12);

        // Reset mid-sequence: next byte is unprefixed.
        send(8'hF0);
        do_reset();
        send(8'h1C);
        pop_chk("rst_mid_a", 8'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
